gf1511_inv: RTL and testbench

Sequential multiplicative-inverse unit for GF(1511). It computes a^(q-2) mod 1511 (Fermat) by constant-time left-to-right square-and-multiply. Each step uses one internal 11x11 modular multiply with Barrett reduction. It sits downstream of the mod-1511 reducers and supplies inverses to field-arithmetic datapaths over valid/ready handshakes on both sides.

---
 rtl/gf1511_inv.sv | 110 +++++++++++
 tb/tb_gf1511_inv.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/gf1511_inv.sv
// Multiplicative inverse in GF(1511) via Fermat exponentiation a^1509.
// Constant-time square-and-multiply over one shared Barrett-reduced 11x11 multiplier.
module gf1511_inv (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [10:0] din_a,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [10:0] dout_r,
    output logic        dout_zero
);

    localparam logic [10:0] Q   = 11'd1511;
    localparam logic [11:0] MU  = 12'd2775;
    localparam logic [10:0] EXP = 11'd1509;

    typedef enum logic [1:0] {IDLE, SQR, MUL, DONE} state_t;

    state_t      state_q, state_d;
    logic [10:0] acc_q, acc_d;
    logic [10:0] a_q, a_d;
    logic [3:0]  idx_q, idx_d;
    logic        zflag_q, zflag_d;

    logic [10:0] mulX, mulY, mulRes, aNorm;
    logic [21:0] prod;
    logic [22:0] est, tq, r0, r1, r2;
    logic [11:0] tHat;

    // Barrett reduction: the estimate undershoots by at most two multiples of Q.
    always_comb begin
        mulX   = acc_q;
        mulY   = (state_q == MUL) ? a_q : acc_q;
        prod   = {11'b0, mulX} * {11'b0, mulY};
        est    = {12'b0, prod[21:11]} * {11'b0, MU};
        tHat   = est[22:11];
        tq     = {11'b0, tHat} * {12'b0, Q};
        r0     = {1'b0, prod} - tq;
        r1     = (r0 >= {12'b0, Q}) ? r0 - {12'b0, Q} : r0;
        r2     = (r1 >= {12'b0, Q}) ? r1 - {12'b0, Q} : r1;
        mulRes = r2[10:0];
    end

    assign aNorm = (din_a >= Q) ? din_a - Q : din_a;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        a_d     = a_q;
        idx_d   = idx_q;
        zflag_d = zflag_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = aNorm;
                    acc_d   = 11'd1;
                    idx_d   = 4'd10;
                    zflag_d = (aNorm == 11'd0);
                    state_d = SQR;
                end
            end
            SQR: begin
                acc_d   = mulRes;
                state_d = MUL;
            end
            MUL: begin
                // The product is computed every step; only the write is bit-dependent.
                if (EXP[idx_q]) begin
                    acc_d = mulRes;
                end
                if (idx_q != 4'd0) begin
                    idx_d   = idx_q - 4'd1;
                    state_d = SQR;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= 11'd0;
            a_q     <= 11'd0;
            idx_q   <= 4'd0;
            zflag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            idx_q   <= idx_d;
            zflag_q <= zflag_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign dout_zero = (state_q == DONE) && zflag_q;
    assign dout_r    = ((state_q == DONE) && !zflag_q) ? acc_q : 11'd0;

endmodule

// File: tb/tb_gf1511_inv.sv
// Self-checking bench for gf1511_inv: directed vector table, hold/reset sequences,
// randomized operands and an exhaustive sweep against a brute-force inverse model.
module tb_gf1511_inv;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [10:0] din_a = 11'd0;
    logic        in_ready, out_valid, dout_zero;
    logic [10:0] dout_r;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gf1511_inv dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din_a     (din_a),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout_r    (dout_r),
        .dout_zero (dout_zero)
    );

    typedef struct {
        logic [10:0] din;
        logic [10:0] expR;
        logic        expZ;
    } vec_t;

    // Reference inverse by exhaustive search over the field.
    function automatic int refInv(input int x);
        int a;
        a = x % 1511;
        if (a == 0) return 0;
        for (int y = 1; y < 1511; y++) begin
            if ((a * y) % 1511 == 1) return y;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Issues one operand, waits for the result, optionally stalls the consumer.
    task automatic applyStimulus(input logic [10:0] val, input int hold, input bit pulse,
                                 output logic [10:0] r, output logic z,
                                 output int lat, output int acceptWait);
        in_valid   = 1'b1;
        din_a      = val;
        acceptWait = 0;
        while (!in_ready && acceptWait < 200) begin
            @(negedge clk);
            acceptWait++;
        end
        checkOutput("accept_bound", 32'(acceptWait < 200), 1);
        @(negedge clk);
        in_valid = 1'b0;
        din_a    = 11'd0;
        checkOutput("busy_in_ready", 32'(in_ready), 0);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        r = dout_r;
        z = dout_zero;
        for (int k = 0; k < hold; k++) begin
            if (pulse && k == 5) begin
                in_valid = 1'b1;
                din_a    = 11'd7;
            end
            @(negedge clk);
            in_valid = 1'b0;
            checkOutput("hold_r", 32'(dout_r), 32'(r));
            checkOutput("hold_zero", 32'(dout_zero), 32'(z));
            checkOutput("hold_valid", 32'(out_valid), 1);
            checkOutput("hold_in_ready", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("post_hs_in_ready", 32'(in_ready), 1);
        checkOutput("post_hs_out_valid", 32'(out_valid), 0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t        vecs[7];
        logic [10:0] r;
        logic        z;
        int          lat, w, v;
        bit          seen;

        vecs[0] = '{11'd2,    11'd756,  1'b0};
        vecs[1] = '{11'd1,    11'd1,    1'b0};
        vecs[2] = '{11'd3,    11'd504,  1'b0};
        vecs[3] = '{11'd1510, 11'd1510, 1'b0};
        vecs[4] = '{11'd0,    11'd0,    1'b1};
        vecs[5] = '{11'd1511, 11'd0,    1'b1};
        vecs[6] = '{11'd1513, 11'd756,  1'b0};

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_in_ready", 32'(in_ready), 1);
        checkOutput("rst_out_valid", 32'(out_valid), 0);
        checkOutput("rst_dout_r", 32'(dout_r), 0);
        checkOutput("rst_dout_zero", 32'(dout_zero), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].din, 0, 1'b0, r, z, lat, w);
            checkOutput("vec_r", 32'(r), 32'(vecs[i].expR));
            checkOutput("vec_zero", 32'(z), 32'(vecs[i].expZ));
            checkOutput("vec_latency", 32'(lat), 22);
            if (i > 0) checkOutput("vec_back_to_back", 32'(w), 0);
        end

        applyStimulus(11'd3, 40, 1'b1, r, z, lat, w);
        checkOutput("stall_r", 32'(r), 504);
        @(negedge clk);
        checkOutput("stall_pulse_ignored", 32'(in_ready), 1);

        in_valid = 1'b1;
        din_a    = 11'd5;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("midrst_in_ready", 32'(in_ready), 1);
        checkOutput("midrst_out_valid", 32'(out_valid), 0);
        checkOutput("midrst_dout_r", 32'(dout_r), 0);
        checkOutput("midrst_dout_zero", 32'(dout_zero), 0);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            seen |= out_valid;
        end
        checkOutput("midrst_no_result", 32'(seen), 0);
        applyStimulus(11'd5, 0, 1'b0, r, z, lat, w);
        checkOutput("fresh5_r", 32'(r), 32'(refInv(5)));
        checkOutput("fresh5_latency", 32'(lat), 22);

        for (int k = 0; k < 20; k++) begin
            v = int'($urandom_range(0, 2047));
            applyStimulus(11'(v), 0, 1'b0, r, z, lat, w);
            checkOutput("rand_r", 32'(r), 32'(refInv(v)));
            checkOutput("rand_zero", 32'(z), 32'(v % 1511 == 0));
            checkOutput("rand_latency", 32'(lat), 22);
        end

        for (int k = 1; k <= 1510; k++) begin
            applyStimulus(11'(k), 0, 1'b0, r, z, lat, w);
            checkOutput("sweep_product", 32'((k * int'(r)) % 1511), 1);
            checkOutput("sweep_zero", 32'(z), 0);
            checkOutput("sweep_latency", 32'(lat), 22);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
